key_event_decoder: RTL and testbench

//  Consumes the 16-bit level-style key vector from the keypad scanner (active-low, 16'hFFFF = no key).

---
 rtl/key_event_pkg.sv | 20 ++
 rtl/key_fifo.sv | 63 ++++++
 rtl/key_event_decoder.sv | 233 +++++++++++++++++++++++
 tb/tb_key_event_decoder.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_event_pkg.sv
// ---------------------------------------------------------------------------
// key_event_pkg
// Shared definitions for the keypad event decoder:
//   key_state_t : decoder FSM state encoding
//   KEYS_NONE   : idle key vector (active-low, no key pressed)
//   KEY_IDX_W   : width of an encoded key index
// ---------------------------------------------------------------------------
package key_event_pkg;

  localparam int          KEY_IDX_W = 4;
  localparam logic [15:0] KEYS_NONE = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    REL_WAIT = 2'd3
  } key_state_t;

endpackage

// File: rtl/key_fifo.sv
// ---------------------------------------------------------------------------
// key_fifo
// Synchronous show-ahead FIFO for encoded key events.
// Parameters: AW (address width, depth = 2**AW), DW (data width).
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_wdata: write request and data (ignored when full unless a pop
//                    happens in the same cycle)
//   i_pop          : remove head entry (ignored when empty)
//   o_rdata        : head entry, valid while !o_empty (0 when empty)
//   o_full/o_empty : occupancy flags
// ---------------------------------------------------------------------------
module key_fifo #(
  parameter int AW = 2,
  parameter int DW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata,
  output logic          o_full,
  output logic          o_empty
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when indices match.
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // When full, a simultaneous pop frees the slot being written.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/key_event_decoder.sv
// ---------------------------------------------------------------------------
// key_event_decoder
// Debounces the active-low 16-bit keypad vector, detects single-key presses,
// encodes each press as a 4-bit index and queues it in a small FIFO for the
// downstream control FSMs.
//
// Optional feature macro: KEY_REPEAT_EN
//   defined   : a held key re-issues its event after REPEAT_DELAY cycles and
//               then every REPEAT_RATE cycles while still held
//   undefined : exactly one event per press
//
// Ports:
//   clkin     in   system clock
//   rst       in   asynchronous reset, active-low
//   keys      in   [15:0] key vector, bit i low = key i pressed
//   key_ack   in   pop head event (ignored when empty)
//   clr_ovf   in   clear sticky overflow flag
//   key_code  out  [3:0] head event index (show-ahead)
//   key_valid out  FIFO not empty
//   fifo_full out  FIFO holds 2**FIFO_AW events
//   overflow  out  sticky: a press was dropped because the FIFO was full
//
// State table
//   IDLE     | no key seen; waits for a key vector change
//   DEBOUNCE | single key candidate latched, counting stable cycles
//   PRESSED  | press accepted and queued, waiting for release
//   REL_WAIT | waiting for all keys released and stable (also absorbs chords)
// ---------------------------------------------------------------------------
module key_event_decoder
  import key_event_pkg::*;
#(
  parameter int DEB_CYCLES   = 1_000_000,
  parameter int CNT_W        = 20,
  parameter int FIFO_AW      = 2,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000,
  parameter int REP_W        = 26
) (
  input  logic                 clkin,
  input  logic                 rst,
  input  logic [15:0]          keys,
  input  logic                 key_ack,
  input  logic                 clr_ovf,
  output logic [KEY_IDX_W-1:0] key_code,
  output logic                 key_valid,
  output logic                 fifo_full,
  output logic                 overflow
);

  // Elaboration-time sanity checks on the counter widths.
  if (DEB_CYCLES < 1 || CNT_W < 1 || CNT_W > 62 ||
      (64'd1 << CNT_W) <= 64'(DEB_CYCLES)) begin : g_bad_cnt_w
    $error("key_event_decoder: CNT_W too narrow for DEB_CYCLES");
  end
  if (REPEAT_DELAY < 1 || REPEAT_RATE < 1 || REP_W < 1 || REP_W > 62 ||
      (64'd1 << REP_W) <= 64'(REPEAT_DELAY) ||
      (64'd1 << REP_W) <= 64'(REPEAT_RATE)) begin : g_bad_rep_w
    $error("key_event_decoder: REP_W too narrow for repeat timing");
  end

  // Returns {onehot, index}: onehot is set when exactly one key is low,
  // index is the position of that low bit.
  function automatic logic [KEY_IDX_W:0] key_encode(input logic [15:0] v);
    logic [15:0]          act;
    logic [KEY_IDX_W-1:0] idx;
    act = ~v;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (act[i]) begin
        idx = KEY_IDX_W'(i);
      end
    end
    return {(act != 16'd0) && ((act & (act - 16'd1)) == 16'd0), idx};
  endfunction

  logic [15:0]          r_sync1;
  logic [15:0]          r_ks;
  key_state_t           r_state;
  logic [15:0]          r_cand;
  logic [KEY_IDX_W-1:0] r_code;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_overflow;

  logic [KEY_IDX_W:0]   w_enc;
  logic                 w_onehot;
  logic [KEY_IDX_W-1:0] w_idx;
  logic                 w_cnt_done;
  logic                 w_accept;
  logic                 w_rep_fire;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_drop;
  logic                 w_full;
  logic                 w_empty;
  logic [KEY_IDX_W-1:0] w_rdata;

  // Two-flop synchronizer; idles at "no key" so reset never looks like a press.
  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      r_sync1 <= KEYS_NONE;
      r_ks    <= KEYS_NONE;
    end else begin
      r_sync1 <= keys;
      r_ks    <= r_sync1;
    end
  end

  assign w_enc      = key_encode(r_ks);
  assign w_onehot   = w_enc[KEY_IDX_W];
  assign w_idx      = w_enc[KEY_IDX_W-1:0];
  assign w_cnt_done = (r_cnt == CNT_W'(DEB_CYCLES - 1));
  // Push is decoded combinationally so the event lands in the FIFO on the
  // same edge the FSM accepts the press.
  assign w_accept   = (r_state == DEBOUNCE) && (r_ks == r_cand) && w_cnt_done;

  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cand  <= KEYS_NONE;
      r_code  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_ks != KEYS_NONE) begin
            r_cnt <= '0;
            if (w_onehot) begin
              r_cand  <= r_ks;
              r_code  <= w_idx;
              r_state <= DEBOUNCE;
            end else begin
              r_state <= REL_WAIT;
            end
          end
        end
        DEBOUNCE: begin
          if (r_ks != r_cand) begin
            r_state <= IDLE;
          end else if (w_cnt_done) begin
            r_state <= PRESSED;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        PRESSED: begin
          // Release and "another key joined" both wait for a clean release.
          if (r_ks != r_cand) begin
            r_cnt   <= '0;
            r_state <= REL_WAIT;
          end
        end
        REL_WAIT: begin
          if (r_ks != KEYS_NONE) begin
            r_cnt <= '0;
          end else if (w_cnt_done) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef KEY_REPEAT_EN
  logic [REP_W-1:0] r_rep_cnt;
  logic             r_rep_armed;
  logic             w_rep_hold;
  logic             w_rep_hit;

  assign w_rep_hold = (r_state == PRESSED) && (r_ks == r_cand);
  // First repeat uses the long delay, later ones the shorter rate.
  assign w_rep_hit  = r_rep_armed ? (r_rep_cnt == REP_W'(REPEAT_RATE - 1))
                                  : (r_rep_cnt == REP_W'(REPEAT_DELAY - 1));
  assign w_rep_fire = w_rep_hold && w_rep_hit;

  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b0;
    end else if (w_rep_hold) begin
      if (w_rep_hit) begin
        r_rep_cnt   <= '0;
        r_rep_armed <= 1'b1;
      end else begin
        r_rep_cnt <= r_rep_cnt + 1'b1;
      end
    end else begin
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b0;
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  assign w_push = w_accept || w_rep_fire;
  assign w_pop  = key_ack && !w_empty;
  // A pop in the same cycle makes room, so only an unpaired push is lost.
  assign w_drop = w_push && w_full && !w_pop;

  key_fifo #(
    .AW (FIFO_AW),
    .DW (KEY_IDX_W)
  ) u_fifo (
    .i_clk   (clkin),
    .i_rst_n (rst),
    .i_push  (w_push),
    .i_pop   (key_ack),
    .i_wdata (r_code),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A new drop wins over a simultaneous clear.
  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  assign key_code  = w_rdata;
  assign key_valid = !w_empty;
  assign fifo_full = w_full;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_key_event_decoder.sv
module tb_key_event_decoder;

  localparam int DEB   = 4;
  localparam int DEPTH = 4;
  localparam int RDEL  = 20;
  localparam int RRATE = 8;
  localparam int LAT   = 2 + DEB + 1;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b1;
  logic [15:0] keys    = 16'hFFFF;
  logic        key_ack = 1'b0;
  logic        clr_ovf = 1'b0;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        fifo_full;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  key_event_decoder #(
    .DEB_CYCLES   (DEB),
    .CNT_W        (3),
    .FIFO_AW      (2),
    .REPEAT_DELAY (RDEL),
    .REPEAT_RATE  (RRATE),
    .REP_W        (26)
  ) dut (
    .clkin     (clk),
    .rst       (rst_n),
    .keys      (keys),
    .key_ack   (key_ack),
    .clr_ovf   (clr_ovf),
    .key_code  (key_code),
    .key_valid (key_valid),
    .fifo_full (fifo_full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] key_of(input int idx);
    logic [15:0] one;
    one = 16'd1 << idx;
    return ~one;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Stimulus only: hold a key, then release it long enough to re-arm.
  task automatic press(input int idx, input int hold, input int rel);
    keys = key_of(idx);
    wait_cycles(hold);
    keys = 16'hFFFF;
    wait_cycles(rel);
  endtask

  task automatic pop_one();
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
  endtask

  task automatic test_reset();
    keys = 16'hFFFF; key_ack = 1'b0; clr_ovf = 1'b0;
    rst_n = 1'b0;
    #1;
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", key_valid); end
    total++; if (key_code !== 4'd0) begin bad++; $display("FAIL reset_code got=%0d want=0", key_code); end
    total++; if (fifo_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b want=0", fifo_full); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b want=0", overflow); end
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(2);
  endtask

  task automatic test_single_press();
    keys = key_of(3);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == LAT - 1) begin
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL press_early got=%0b want=0", key_valid); end
      end
      if (n == LAT) begin
        total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL press_valid got=%0b want=1", key_valid); end
        total++; if (key_code !== 4'd3) begin bad++; $display("FAIL press_code got=%0d want=3", key_code); end
      end
    end
    keys = 16'hFFFF;
    wait_cycles(3);
    pop_one();
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL press_single_event got=%0b want=0", key_valid); end
    wait_cycles(8);
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL release_no_event got=%0b want=0", key_valid); end
  endtask

  task automatic test_bounce();
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 16; n++) begin
      keys = ((n / 2) % 2 == 0) ? key_of(0) : 16'hFFFF;
      @(negedge clk);
      if (key_valid) seen = 1'b1;
    end
    keys = 16'hFFFF;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (key_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL bounce_event got=%0b want=0", seen); end
  endtask

  task automatic test_chord();
    logic seen;
    seen = 1'b0;
    keys = 16'hFFFC;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (key_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL chord_event got=%0b want=0", seen); end
    keys = 16'hFFFF;
    wait_cycles(DEB);
    keys = 16'h7FFF;
    wait_cycles(LAT);
    total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL chord_after_valid got=%0b want=1", key_valid); end
    total++; if (key_code !== 4'd15) begin bad++; $display("FAIL chord_after_code got=%0d want=15", key_code); end
    keys = 16'hFFFF;
    pop_one();
    wait_cycles(7);
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= 5; k++) press(k, 6, 7);
    total++; if (fifo_full !== 1'b1) begin bad++; $display("FAIL ovf_full got=%0b want=1", fifo_full); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b want=1", overflow); end
    for (int k = 1; k <= 4; k++) begin
      total++; if (key_code !== 4'(k)) begin bad++; $display("FAIL ovf_pop_code got=%0d want=%0d", key_code, k); end
      pop_one();
    end
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%0b want=0", key_valid); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b want=1", overflow); end
  endtask

  task automatic test_push_pop_full();
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clr_ovf got=%0b want=0", overflow); end
    for (int k = 8; k <= 11; k++) press(k, 6, 7);
    total++; if (fifo_full !== 1'b1) begin bad++; $display("FAIL ppf_full_before got=%0b want=1", fifo_full); end
    keys = key_of(12);
    wait_cycles(LAT - 1);
    pop_one();
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ppf_ovf got=%0b want=0", overflow); end
    total++; if (fifo_full !== 1'b1) begin bad++; $display("FAIL ppf_full_after got=%0b want=1", fifo_full); end
    keys = 16'hFFFF;
    for (int k = 9; k <= 12; k++) begin
      total++; if (key_code !== 4'(k)) begin bad++; $display("FAIL ppf_seq got=%0d want=%0d", key_code, k); end
      pop_one();
    end
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL ppf_drained got=%0b want=0", key_valid); end
    wait_cycles(7);
  endtask

  task automatic test_reset_mid();
    press(1, 6, 7);
    press(2, 6, 7);
    total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL rmid_buffered got=%0b want=1", key_valid); end
    keys = key_of(6);
    wait_cycles(4);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%0b want=0", key_valid); end
    total++; if (key_code !== 4'd0) begin bad++; $display("FAIL rmid_code got=%0d want=0", key_code); end
    total++; if (fifo_full !== 1'b0) begin bad++; $display("FAIL rmid_full got=%0b want=0", fifo_full); end
    @(negedge clk);
    keys  = 16'hFFFF;
    rst_n = 1'b1;
    wait_cycles(3);
    keys = key_of(13);
    wait_cycles(LAT);
    total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL rmid_after_valid got=%0b want=1", key_valid); end
    total++; if (key_code !== 4'd13) begin bad++; $display("FAIL rmid_after_code got=%0d want=13", key_code); end
    keys = 16'hFFFF;
    pop_one();
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL rmid_only_one got=%0b want=0", key_valid); end
    wait_cycles(7);
  endtask

  task automatic test_repeat();
    localparam int HOLD = 60;
    int exp_t[$];
    int got_t[$];
    int t;
    // Event edges counted from the first edge that samples the pressed key.
    exp_t.push_back(LAT);
`ifdef KEY_REPEAT_EN
    t = LAT + RDEL;
    while (t <= HOLD + 2) begin
      exp_t.push_back(t);
      t += RRATE;
    end
`endif
    keys = key_of(7);
    for (int n = 1; n <= HOLD + 20; n++) begin
      @(negedge clk);
      key_ack = 1'b0;
      if (n == HOLD) keys = 16'hFFFF;
      if (key_valid) begin
        got_t.push_back(n);
        total++; if (key_code !== 4'd7) begin bad++; $display("FAIL repeat_code got=%0d want=7", key_code); end
        key_ack = 1'b1;
      end
    end
    key_ack = 1'b0;
    total++; if (got_t.size() != exp_t.size()) begin bad++; $display("FAIL repeat_count got=%0d want=%0d", got_t.size(), exp_t.size()); end
    for (int i = 0; i < exp_t.size() && i < got_t.size(); i++) begin
      total++; if (got_t[i] != exp_t[i]) begin bad++; $display("FAIL repeat_time[%0d] got=%0d want=%0d", i, got_t[i], exp_t[i]); end
    end
    wait_cycles(4);
  endtask

  task automatic test_random();
    logic [15:0] stim[$];
    int          ev_edge[$];
    int          ev_code[$];
    int          exp_push[];
    logic [3:0]  mq[$];
    logic        mov;
    int          r, len, kind, i0, j0, start, n;
    logic [15:0] p;
    logic        a, c, pop, psh, drop;

    for (int s = 0; s < 25; s++) begin
      r = $urandom_range(6, 10);
      repeat (r) stim.push_back(16'hFFFF);
      kind  = $urandom_range(0, 9);
      len   = $urandom_range(1, 10);
      i0    = $urandom_range(0, 15);
      start = stim.size();
      if (kind < 7) begin
        p = key_of(i0);
        // A single key held for DEB+1 sampled cycles yields one event.
        if (len >= DEB + 1) begin
          ev_edge.push_back(start + DEB + 2);
          ev_code.push_back(i0);
        end
      end else begin
        j0 = (i0 + $urandom_range(1, 15)) % 16;
        p  = key_of(i0) & key_of(j0);
      end
      repeat (len) stim.push_back(p);
    end
    repeat (12) stim.push_back(16'hFFFF);
    n = stim.size();
    exp_push = new[n];
    for (int k = 0; k < n; k++) exp_push[k] = -1;
    for (int e = 0; e < ev_edge.size(); e++) exp_push[ev_edge[e]] = ev_code[e];

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mov = 1'b0;
    for (int k = 0; k < n; k++) begin
      keys    = stim[k];
      a       = ($urandom_range(0, 7) == 0);
      c       = ($urandom_range(0, 19) == 0);
      key_ack = a;
      clr_ovf = c;
      @(posedge clk);
      pop  = a && (mq.size() > 0);
      psh  = (exp_push[k] >= 0);
      drop = psh && (mq.size() == DEPTH) && !pop;
      if (pop) void'(mq.pop_front());
      if (psh && !drop) mq.push_back(4'(exp_push[k]));
      if (drop) mov = 1'b1;
      else if (c) mov = 1'b0;
      @(negedge clk);
      total++; if (key_valid !== (mq.size() > 0)) begin bad++; $display("FAIL rnd_valid k=%0d got=%0b want=%0b", k, key_valid, mq.size() > 0); end
      total++; if (fifo_full !== (mq.size() == DEPTH)) begin bad++; $display("FAIL rnd_full k=%0d got=%0b want=%0b", k, fifo_full, mq.size() == DEPTH); end
      total++; if (overflow !== mov) begin bad++; $display("FAIL rnd_ovf k=%0d got=%0b want=%0b", k, overflow, mov); end
      if (mq.size() > 0) begin
        total++; if (key_code !== mq[0]) begin bad++; $display("FAIL rnd_code k=%0d got=%0d want=%0d", k, key_code, mq[0]); end
      end
    end
    key_ack = 1'b0;
    clr_ovf = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_chord();
    test_overflow();
    test_push_pop_full();
    test_reset_mid();
    test_repeat();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
